// File: rtl/instdecode.sv
// Fetch/decode/execute sequencer for the 8-bit core: 3 cycles per instruction, 4 with writeback.
// No backpressure: runs every cycle until HLT; active-low reset forces every output low at once.
module instdecode (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic        alu_zero,
  input  logic        alu_carry,
  output logic        fetch_en,
  output logic        loadPC,
  output logic        incPC,
  output logic [5:0]  address,
  output logic [2:0]  rd_sel,
  output logic [2:0]  rs_sel,
  output logic [3:0]  alu_op,
  output logic [7:0]  imm8,
  output logic        reg_we,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  localparam logic [3:0] OP_LD  = 4'h9;
  localparam logic [3:0] OP_ST  = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_JZ  = 4'hC;
  localparam logic [3:0] OP_JC  = 4'hD;
  localparam logic [3:0] OP_CMP = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        z_q, z_d;
  logic        c_q, c_d;

  logic [3:0] op;
  logic       take_jump;
  logic       fe_s, ld_s, inc_s, we_s, rd_s, wr_s, hlt_s;

  assign op = ir_q[15:12];

  // Branches test the latched flags, never the live ALU inputs.
  assign take_jump = (op == OP_JMP) || ((op == OP_JZ) && z_q) || ((op == OP_JC) && c_q);

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    z_d     = z_q;
    c_d     = c_q;
    fe_s    = 1'b0;
    ld_s    = 1'b0;
    inc_s   = 1'b0;
    we_s    = 1'b0;
    rd_s    = 1'b0;
    wr_s    = 1'b0;
    hlt_s   = 1'b0;
    case (state_q)
      S_FETCH: begin
        fe_s    = 1'b1;
        ir_d    = instruction;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if ((op >= 4'h1 && op <= 4'h6) || op == OP_CMP) begin
          z_d = alu_zero;
          c_d = alu_carry;
        end
        rd_s = (op == OP_LD);
        wr_s = (op == OP_ST);
        if (op != OP_HLT) begin
          ld_s  = take_jump;
          inc_s = !take_jump;
        end
        if (op >= 4'h1 && op <= 4'h9) begin
          state_d = S_WRITEBACK;
        end else if (op == OP_HLT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WRITEBACK: begin
        we_s    = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        hlt_s = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      ir_q    <= 16'h0000;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  // Gating with reset drops strobes in the same instant reset falls, not at the next edge.
  assign fetch_en = fe_s  & reset;
  assign loadPC   = ld_s  & reset;
  assign incPC    = inc_s & reset;
  assign reg_we   = we_s  & reset;
  assign mem_rd   = rd_s  & reset;
  assign mem_wr   = wr_s  & reset;
  assign halted   = hlt_s & reset;

  assign address = ir_q[5:0];
  assign rd_sel  = ir_q[11:9];
  assign rs_sel  = ir_q[8:6];
  assign alu_op  = ir_q[15:12];
  assign imm8    = ir_q[7:0];

endmodule

// File: tb/tb_instdecode.sv
// Scoreboarded bench for instdecode: per-cycle expected strobes/fields queued by stimulus, popped by a negedge monitor.
module tb_instdecode;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic        alu_zero, alu_carry;
  logic        fetch_en, loadPC, incPC, reg_we, mem_rd, mem_wr, halted;
  logic [5:0]  address;
  logic [2:0]  rd_sel, rs_sel;
  logic [3:0]  alu_op;
  logic [7:0]  imm8;

  instdecode dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .alu_zero    (alu_zero),
    .alu_carry   (alu_carry),
    .fetch_en    (fetch_en),
    .loadPC      (loadPC),
    .incPC       (incPC),
    .address     (address),
    .rd_sel      (rd_sel),
    .rs_sel      (rs_sel),
    .alu_op      (alu_op),
    .imm8        (imm8),
    .reg_we      (reg_we),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Strobe vector order: fetch_en, loadPC, incPC, reg_we, mem_rd, mem_wr, halted
  localparam logic [6:0] S_NONE = 7'b0000000;
  localparam logic [6:0] S_FE   = 7'b1000000;
  localparam logic [6:0] S_LD   = 7'b0100000;
  localparam logic [6:0] S_INC  = 7'b0010000;
  localparam logic [6:0] S_WE   = 7'b0001000;
  localparam logic [6:0] S_RD   = 7'b0000100;
  localparam logic [6:0] S_WR   = 7'b0000010;
  localparam logic [6:0] S_HLT  = 7'b0000001;

  typedef struct {
    string       name;
    logic [6:0]  strb;
    logic        chk;
    logic [23:0] fld;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic mon_en   = 1'b0;

  // Field vector order: address, rd_sel, rs_sel, alu_op, imm8
  function automatic logic [23:0] fields_of(input logic [15:0] ins);
    return {ins[5:0], ins[11:9], ins[8:6], ins[15:12], ins[7:0]};
  endfunction

  task automatic push(input string nm, input logic [6:0] s, input logic c, input logic [23:0] f);
    exp_t e;
    e.name = nm;
    e.strb = s;
    e.chk  = c;
    e.fld  = f;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t        e;
      logic [6:0]  act_s;
      logic [23:0] act_f;
      act_s = {fetch_en, loadPC, incPC, reg_we, mem_rd, mem_wr, halted};
      act_f = {address, rd_sel, rs_sel, alu_op, imm8};
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL underflow: DUT cycle with no expectation, strobes=%b", act_s);
      end else begin
        e = sb_q.pop_front();
        if (act_s !== e.strb) begin
          n_errors++;
          $display("FAIL %s strobes: got %b expected %b", e.name, act_s, e.strb);
        end
        if (e.chk) begin
          n_checks++;
          if (act_f !== e.fld) begin
            n_errors++;
            $display("FAIL %s fields: got %h expected %h", e.name, act_f, e.fld);
          end
        end
      end
    end
  end

  // Runs one instruction from FETCH; with abort set, stops at the start of WRITEBACK.
  task automatic issue(input string nm, input logic [15:0] ins, input logic az, input logic ac,
                       input int ncyc, input logic [6:0] xs, input bit abort);
    logic [23:0] f;
    int          run;
    f           = fields_of(ins);
    instruction = ins;
    alu_zero    = az;
    alu_carry   = ac;
    push({nm, " fetch"}, S_FE, 1'b0, 24'h0);
    push({nm, " decode"}, S_NONE, 1'b1, f);
    push({nm, " execute"}, xs, 1'b1, f);
    if (ncyc == 4 && !abort) push({nm, " writeback"}, S_WE, 1'b1, f);
    run = abort ? ncyc - 1 : ncyc;
    for (int i = 0; i < run; i++) begin
      @(posedge clk);
      #1;
      instruction = ~ins;
    end
  endtask

  // Called at posedge+1; reset is low across n negedges, then released.
  task automatic reset_pulse(input string nm, input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      push(nm, S_NONE, 1'b1, 24'h0);
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b0;
    instruction = 16'h0000;
    alu_zero    = 1'b0;
    alu_carry   = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    reset_pulse("reset_state", 2);

    issue("ldi_r1_2a",    16'h822A, 1'b0, 1'b0, 4, S_INC, 1'b0);
    issue("add_zero",     16'h14C0, 1'b1, 1'b0, 4, S_INC, 1'b0);
    issue("jz_taken",     16'hC015, 1'b0, 1'b0, 3, S_LD, 1'b0);
    issue("jc_not_taken", 16'hD030, 1'b0, 1'b1, 3, S_INC, 1'b0);
    issue("st_r3_r5",     16'hA740, 1'b0, 1'b0, 3, S_WR | S_INC, 1'b0);
    issue("ld_r2_r7",     16'h95C0, 1'b0, 1'b0, 4, S_RD | S_INC, 1'b0);
    issue("cmp_carry",    16'hE2C0, 1'b0, 1'b1, 3, S_INC, 1'b0);
    issue("nop_keep",     16'h0000, 1'b1, 1'b0, 3, S_INC, 1'b0);
    issue("jc_taken",     16'hD007, 1'b0, 1'b0, 3, S_LD, 1'b0);
    issue("jz_z_clear",   16'hC03F, 1'b1, 1'b0, 3, S_INC, 1'b0);
    issue("jmp",          16'hB025, 1'b0, 1'b0, 3, S_LD, 1'b0);

    issue("add_abort",    16'h1000, 1'b1, 1'b1, 4, S_INC, 1'b1);
    reset_pulse("reset_in_writeback", 2);
    issue("jz_after_rst", 16'hC011, 1'b1, 1'b0, 3, S_INC, 1'b0);
    issue("jc_after_rst", 16'hD012, 1'b0, 1'b1, 3, S_INC, 1'b0);

    issue("hlt",          16'hF000, 1'b0, 1'b0, 3, S_NONE, 1'b0);
    for (int i = 0; i < 10; i++) begin
      push("halt_hold", S_HLT, 1'b1, fields_of(16'hF000));
      instruction = 16'($urandom);
      @(posedge clk);
      #1;
    end
    reset_pulse("reset_from_halt", 1);
    issue("ldi_r7_55",    16'h8E55, 1'b0, 1'b0, 4, S_INC, 1'b0);

    mon_en = 1'b0;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL leftover: got %0d unconsumed expectations, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
